// File: rtl/vslc_pkg.sv
// Shared types and constants for the VSLC process-image front end.
package vslc_pkg;

  localparam int SCAN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_RUN    = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_e;

endpackage

// File: rtl/vslc_io_image_if.sv
// Core-facing scan bus: the core drives scan control and output writes,
// the I/O image returns the latched input images and scan status.
interface vslc_io_image_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);

  logic             scan_start;
  logic             scan_done;
  logic             out_wr;
  logic [OUT_W-1:0] out_data;
  logic [IN_W-1:0]  img_in;
  logic [IN_W-1:0]  img_rise;
  logic [IN_W-1:0]  img_fall;
  logic             img_valid;
  logic             busy;

  modport master (
    output scan_start, scan_done, out_wr, out_data,
    input  img_in, img_rise, img_fall, img_valid, busy
  );

  modport slave (
    input  scan_start, scan_done, out_wr, out_data,
    output img_in, img_rise, img_fall, img_valid, busy
  );

endinterface

// File: rtl/vslc_debounce.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by a counter
// debouncer that accepts a new level after DEB_MAX consecutive synced cycles.
module vslc_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_BITS    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'((1 << DEB_BITS) - 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_BITS-1:0]    cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + DEB_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/vslc_io_image.sv
// Scan-cycle process image: debounced input images latched at scan start,
// staged outputs committed at scan end. Optional watchdog via VSLC_WDOG_EN.
module vslc_io_image
  import vslc_pkg::*;
#(
  parameter int               IN_W        = 8,
  parameter int               OUT_W       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               DEB_BITS    = 4,
  parameter int               WDOG_W      = 12,
  parameter logic [OUT_W-1:0] SAFE_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [IN_W-1:0]       in_raw,
  vslc_io_image_if.slave        core,
  output logic [OUT_W-1:0]      out_pins,
  output logic [SCAN_CNT_W-1:0] scan_count,
  output logic                  overrun,
  output logic                  fault
);

  scan_state_e           state_q, state_d;
  logic [IN_W-1:0]       stable;
  logic [IN_W-1:0]       img_in_q, img_in_d;
  logic [IN_W-1:0]       img_rise_q, img_rise_d;
  logic [IN_W-1:0]       img_fall_q, img_fall_d;
  logic [OUT_W-1:0]      out_stage_q, out_stage_d;
  logic [OUT_W-1:0]      out_pins_q, out_pins_d;
  logic [SCAN_CNT_W-1:0] scan_count_q, scan_count_d;
  logic                  overrun_q, overrun_d;
  logic                  img_valid;
  logic                  busy;
  logic                  wdog_trip;

  for (genvar i = 0; i < IN_W; i++) begin : gen_ch
    vslc_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_BITS    (DEB_BITS)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (in_raw[i]),
      .stable (stable[i])
    );
  end

`ifdef VSLC_WDOG_EN
  // Trip on the edge where the RUN-cycle count would reach its all-ones value.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((1 << WDOG_W) - 2);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              fault_q, fault_d;

  always_comb begin
    wdog_d  = wdog_q;
    fault_d = fault_q;
    if (state_q == ST_LATCH) begin
      wdog_d = '0;
    end else if (state_q == ST_RUN) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    wdog_trip = (state_q == ST_RUN) && !core.scan_done && (wdog_q == WDOG_LAST);
    if (wdog_trip) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign wdog_trip = 1'b0;
  assign fault     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (core.scan_start && ena) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: state_d = ST_RUN;
      ST_RUN: begin
        if (core.scan_done) begin
          state_d = ST_COMMIT;
        end else if (wdog_trip) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    img_valid = (state_q == ST_RUN);
    busy      = (state_q != ST_IDLE);
  end

  // Edge images compare against the image latched by the previous scan.
  always_comb begin
    img_in_d     = img_in_q;
    img_rise_d   = img_rise_q;
    img_fall_d   = img_fall_q;
    out_stage_d  = out_stage_q;
    out_pins_d   = out_pins_q;
    scan_count_d = scan_count_q;
    overrun_d    = overrun_q | (core.scan_start && busy);

    if (state_q == ST_LATCH) begin
      img_in_d   = stable;
      img_rise_d = stable & ~img_in_q;
      img_fall_d = ~stable & img_in_q;
    end

    if ((state_q == ST_RUN) && core.out_wr) begin
      out_stage_d = core.out_data;
    end

    if (state_q == ST_COMMIT) begin
      out_pins_d   = out_stage_q;
      scan_count_d = scan_count_q + SCAN_CNT_W'(1);
    end

    if (wdog_trip) begin
      out_stage_d = SAFE_VAL;
      out_pins_d  = SAFE_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_in_q     <= '0;
      img_rise_q   <= '0;
      img_fall_q   <= '0;
      out_stage_q  <= '0;
      out_pins_q   <= '0;
      scan_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      img_in_q     <= img_in_d;
      img_rise_q   <= img_rise_d;
      img_fall_q   <= img_fall_d;
      out_stage_q  <= out_stage_d;
      out_pins_q   <= out_pins_d;
      scan_count_q <= scan_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign core.img_in    = img_in_q;
  assign core.img_rise  = img_rise_q;
  assign core.img_fall  = img_fall_q;
  assign core.img_valid = img_valid;
  assign core.busy      = busy;
  assign out_pins       = out_pins_q;
  assign scan_count     = scan_count_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_vslc_io_image.sv
// Directed bench for vslc_io_image (DEB_BITS=2, SYNC_STAGES=2, WDOG_W=4,
// SAFE_VAL=8'h81); watchdog scenarios run when VSLC_WDOG_EN is defined.
module tb_vslc_io_image;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [7:0]  in_raw;
  logic [7:0]  out_pins;
  logic [15:0] scan_count;
  logic        overrun;
  logic        fault;

  int errors;
  int checks;
  int exp_count;

  vslc_io_image_if #(.IN_W(8), .OUT_W(8)) bus ();

  vslc_io_image #(
    .IN_W        (8),
    .OUT_W       (8),
    .SYNC_STAGES (2),
    .DEB_BITS    (2),
    .WDOG_W      (4),
    .SAFE_VAL    (8'h81)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_raw     (in_raw),
    .core       (bus),
    .out_pins   (out_pins),
    .scan_count (scan_count),
    .overrun    (overrun),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the DUT at the start of the first RUN cycle.
  task automatic start_scan();
    bus.scan_start = 1'b1;
    step(1);
    bus.scan_start = 1'b0;
    step(1);
  endtask

  // Leaves the DUT in IDLE with the commit visible.
  task automatic finish_scan();
    bus.scan_done = 1'b1;
    step(1);
    bus.scan_done = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    checks++; if (out_pins !== 8'h00) begin errors++; $display("[TB] FAIL reset_pins: got %h expected %h", out_pins, 8'h00); end
    checks++; if (scan_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count: got %h expected %h", scan_count, 16'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.img_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.img_valid); end
    checks++; if ({overrun, fault} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {overrun, fault}); end
    checks++; if (bus.img_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_img: got %h expected %h", bus.img_in, 8'h00); end
    rst_n = 1'b1;
    step(1);
    exp_count = 0;
  endtask

  task automatic test_debounce();
    logic seen;
    in_raw[0] = 1'b1;
    step(4);
    checks++; if (dut.stable[0] !== 1'b0) begin errors++; $display("[TB] FAIL deb_early: got %b expected 0", dut.stable[0]); end
    step(1);
    checks++; if (dut.stable[0] !== 1'b1) begin errors++; $display("[TB] FAIL deb_step: got %b expected 1", dut.stable[0]); end
    seen = 1'b0;
    in_raw[1] = 1'b1;
    step(1);
    if (dut.stable[1]) seen = 1'b1;
    step(1);
    in_raw[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dut.stable[1]) seen = 1'b1;
      step(1);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL deb_pulse: got %b expected 0", seen); end
  endtask

  task automatic test_edge_images();
    in_raw = 8'h05;
    step(8);
    bus.scan_start = 1'b1;
    step(1);
    bus.scan_start = 1'b0;
    checks++; if (bus.img_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_t1: got %b expected 0", bus.img_valid); end
    step(1);
    checks++; if (bus.img_valid !== 1'b1) begin errors++; $display("[TB] FAIL valid_t2: got %b expected 1", bus.img_valid); end
    checks++; if (bus.img_in !== 8'h05) begin errors++; $display("[TB] FAIL img_in_1: got %h expected %h", bus.img_in, 8'h05); end
    checks++; if (bus.img_rise !== 8'h05) begin errors++; $display("[TB] FAIL rise_1: got %h expected %h", bus.img_rise, 8'h05); end
    checks++; if (bus.img_fall !== 8'h00) begin errors++; $display("[TB] FAIL fall_1: got %h expected %h", bus.img_fall, 8'h00); end
    finish_scan();
    exp_count++;
    in_raw = 8'h0C;
    step(8);
    start_scan();
    checks++; if (bus.img_in !== 8'h0C) begin errors++; $display("[TB] FAIL img_in_2: got %h expected %h", bus.img_in, 8'h0C); end
    checks++; if (bus.img_rise !== 8'h08) begin errors++; $display("[TB] FAIL rise_2: got %h expected %h", bus.img_rise, 8'h08); end
    checks++; if (bus.img_fall !== 8'h01) begin errors++; $display("[TB] FAIL fall_2: got %h expected %h", bus.img_fall, 8'h01); end
    finish_scan();
    exp_count++;
    in_raw = 8'hF0;
    step(3);
    checks++; if (bus.img_in !== 8'h0C) begin errors++; $display("[TB] FAIL img_hold: got %h expected %h", bus.img_in, 8'h0C); end
    checks++; if (bus.img_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_idle: got %b expected 0", bus.img_valid); end
  endtask

  task automatic test_commit();
    start_scan();
    bus.out_wr = 1'b1;
    bus.out_data = 8'hAA;
    step(1);
    bus.out_data = 8'h3C;
    step(1);
    bus.out_wr = 1'b0;
    checks++; if (out_pins !== 8'h00) begin errors++; $display("[TB] FAIL pins_run: got %h expected %h", out_pins, 8'h00); end
    bus.scan_done = 1'b1;
    step(1);
    bus.scan_done = 1'b0;
    checks++; if (out_pins !== 8'h00) begin errors++; $display("[TB] FAIL pins_t1: got %h expected %h", out_pins, 8'h00); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_t1: got %b expected 1", bus.busy); end
    step(1);
    exp_count++;
    checks++; if (out_pins !== 8'h3C) begin errors++; $display("[TB] FAIL pins_commit: got %h expected %h", out_pins, 8'h3C); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_t2: got %b expected 0", bus.busy); end
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL count_commit: got %0d expected %0d", scan_count, exp_count); end
    start_scan();
    bus.out_wr = 1'b1;
    bus.out_data = 8'h77;
    bus.scan_done = 1'b1;
    step(1);
    bus.out_wr = 1'b0;
    bus.scan_done = 1'b0;
    step(1);
    exp_count++;
    checks++; if (out_pins !== 8'h77) begin errors++; $display("[TB] FAIL pins_same_cycle: got %h expected %h", out_pins, 8'h77); end
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL count_same_cycle: got %0d expected %0d", scan_count, exp_count); end
    bus.out_wr = 1'b1;
    bus.out_data = 8'h55;
    step(1);
    bus.out_wr = 1'b0;
    bus.scan_done = 1'b1;
    step(1);
    bus.scan_done = 1'b0;
    step(1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL done_idle_busy: got %b expected 0", bus.busy); end
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL done_idle_count: got %0d expected %0d", scan_count, exp_count); end
    start_scan();
    finish_scan();
    exp_count++;
    checks++; if (out_pins !== 8'h77) begin errors++; $display("[TB] FAIL pins_recommit: got %h expected %h", out_pins, 8'h77); end
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL count_recommit: got %0d expected %0d", scan_count, exp_count); end
  endtask

  task automatic test_overrun_ena();
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_clear: got %b expected 0", overrun); end
    start_scan();
    bus.scan_start = 1'b1;
    step(1);
    bus.scan_start = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b expected 1", overrun); end
    checks++; if (bus.img_valid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_run: got %b expected 1", bus.img_valid); end
    finish_scan();
    exp_count++;
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL overrun_count: got %0d expected %0d", scan_count, exp_count); end
    ena = 1'b0;
    bus.scan_start = 1'b1;
    step(1);
    bus.scan_start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ena_block: got %b expected 0", bus.busy); end
    step(1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ena_block2: got %b expected 0", bus.busy); end
    ena = 1'b1;
    start_scan();
    ena = 1'b0;
    finish_scan();
    exp_count++;
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL ena_midscan: got %0d expected %0d", scan_count, exp_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ena_midscan_busy: got %b expected 0", bus.busy); end
    ena = 1'b1;
  endtask

  task automatic test_reset_mid_scan();
    start_scan();
    bus.out_wr = 1'b1;
    bus.out_data = 8'hFF;
    step(1);
    bus.out_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_pins !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_pins: got %h expected %h", out_pins, 8'h00); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    checks++; if (scan_count !== 16'h0) begin errors++; $display("[TB] FAIL rst_mid_count: got %0d expected 0", scan_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_overrun: got %b expected 0", overrun); end
    step(2);
    rst_n = 1'b1;
    step(1);
    exp_count = 0;
    start_scan();
    finish_scan();
    exp_count++;
    checks++; if (out_pins !== 8'h00) begin errors++; $display("[TB] FAIL rst_stage_cleared: got %h expected %h", out_pins, 8'h00); end
  endtask

`ifdef VSLC_WDOG_EN
  task automatic test_watchdog();
    start_scan();
    bus.out_wr = 1'b1;
    bus.out_data = 8'h5A;
    step(1);
    bus.out_wr = 1'b0;
    step(13);
    bus.scan_done = 1'b1;
    step(1);
    bus.scan_done = 1'b0;
    step(1);
    exp_count++;
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL wdog_done_wins_fault: got %b expected 0", fault); end
    checks++; if (out_pins !== 8'h5A) begin errors++; $display("[TB] FAIL wdog_done_wins_pins: got %h expected %h", out_pins, 8'h5A); end
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL wdog_done_wins_count: got %0d expected %0d", scan_count, exp_count); end
    start_scan();
    step(14);
    checks++; if ({bus.busy, fault} !== 2'b10) begin errors++; $display("[TB] FAIL wdog_pre_trip: got %b expected 10", {bus.busy, fault}); end
    step(1);
    checks++; if (out_pins !== 8'h81) begin errors++; $display("[TB] FAIL wdog_pins: got %h expected %h", out_pins, 8'h81); end
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL wdog_fault: got %b expected 1", fault); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL wdog_busy: got %b expected 0", bus.busy); end
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL wdog_count: got %0d expected %0d", scan_count, exp_count); end
    start_scan();
    finish_scan();
    exp_count++;
    checks++; if (out_pins !== 8'h81) begin errors++; $display("[TB] FAIL wdog_stage: got %h expected %h", out_pins, 8'h81); end
    checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL wdog_sticky: got %b expected 1", fault); end
  endtask
`else
  task automatic test_no_watchdog();
    start_scan();
    step(40);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL long_run_busy: got %b expected 1", bus.busy); end
    checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL long_run_fault: got %b expected 0", fault); end
    finish_scan();
    exp_count++;
    checks++; if (scan_count !== 16'(exp_count)) begin errors++; $display("[TB] FAIL long_run_count: got %0d expected %0d", scan_count, exp_count); end
  endtask
`endif

  initial begin
    errors         = 0;
    checks         = 0;
    exp_count      = 0;
    rst_n          = 1'b0;
    ena            = 1'b1;
    in_raw         = 8'h00;
    bus.scan_start = 1'b0;
    bus.scan_done  = 1'b0;
    bus.out_wr     = 1'b0;
    bus.out_data   = 8'h00;

    test_reset();
    test_debounce();
    test_edge_images();
    test_commit();
    test_overrun_ena();
    test_reset_mid_scan();
`ifdef VSLC_WDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
